status_frame_tx: RTL

Transmit-side framer and UART serializer for the link to the ESP8266 WiFi module; the transmit counterpart of the receive-side decoder. Snapshots an 8-bit actuator/status word and an 8-bit auxiliary byte and serializes them as a fixed 5-byte checksummed frame on the UART `tx` line. A frame is sent periodically on 1 Hz ticks and immediately whenever the status word changes. It sits beside the receive path in the top level and drives the board's `tx` pin directly.

---
 rtl/planta_pkg.sv | 28 ++
 rtl/uart_byte_tx.sv | 84 ++++++++
 rtl/status_frame_tx.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/planta_pkg.sv
`default_nettype none
// ============================================================================
// Module   : planta_pkg
// Purpose  : Shared constants and FSM state type for the ESP8266 status link.
// Revision : 1.0 - initial release
// ============================================================================
package planta_pkg;

    localparam logic [7:0] SOF_DEFAULT   = 8'h7E;
    localparam logic [7:0] FTYPE_DEFAULT = 8'h01;
    localparam int         FRAME_LEN     = 5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SEND = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } tx_state_e;

    function automatic logic [7:0] frame_chk(input logic [7:0] ftype,
                                             input logic [7:0] s,
                                             input logic [7:0] a);
        return ftype ^ s ^ a;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_byte_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_byte_tx
// Purpose  : 8N1 UART byte serializer; accepts a new byte in its done cycle.
// Revision : 1.0 - initial release
// ============================================================================
module uart_byte_tx #(
    parameter int BAUD_DIV = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int             CW        = $clog2(BAUD_DIV);
    localparam logic [CW-1:0]  BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [3:0]     STOP_IDX  = 4'd9;

    logic          active_q, active_d;
    logic [CW-1:0] baud_q,   baud_d;
    logic [3:0]    bit_q,    bit_d;
    logic [7:0]    shift_q,  shift_d;
    logic          tx_q,     tx_d;
    logic          w_done;
    logic          w_accept;

    always_comb begin
        active_d = active_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        w_done   = active_q && (bit_q == STOP_IDX) && (baud_q == BAUD_LAST);
        w_accept = start && (!active_q || w_done);

        if (w_accept) begin
            active_d = 1'b1;
            baud_d   = '0;
            bit_d    = 4'd0;
            shift_d  = data;
            tx_d     = 1'b0;
        end else if (active_q) begin
            if (baud_q == BAUD_LAST) begin
                baud_d = '0;
                if (bit_q == STOP_IDX) begin
                    active_d = 1'b0;
                end else begin
                    // Shifting in ones means the stop bit falls out after bit 7.
                    bit_d   = bit_q + 4'd1;
                    tx_d    = shift_q[0];
                    shift_d = {1'b1, shift_q[7:1]};
                end
            end else begin
                baud_d = baud_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
            baud_q   <= '0;
            bit_q    <= 4'd0;
            shift_q  <= 8'hFF;
            tx_q     <= 1'b1;
        end else begin
            active_q <= active_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
        end
    end

    assign tx   = tx_q;
    assign busy = active_q;
    assign done = w_done;

endmodule
`default_nettype wire

// File: rtl/status_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : status_frame_tx
// Purpose  : Periodic / on-change 5-byte status framer driving the UART tx pin.
// Revision : 1.0 - initial release
// ============================================================================
module status_frame_tx
    import planta_pkg::*;
#(
    parameter int         BAUD_DIV     = 5208,
    parameter int         PERIOD_TICKS = 5,
    parameter logic [7:0] SOF          = SOF_DEFAULT,
    parameter logic [7:0] FTYPE        = FTYPE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [7:0] status,
    input  logic [7:0] aux,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [2:0] LAST_IDX    = 3'(FRAME_LEN - 1);
    localparam logic [7:0] TICK_LAST   = 8'(PERIOD_TICKS - 1);

    tx_state_e  state_q, state_d;
    logic [2:0] idx_q,   idx_d;
    logic [7:0] s_q,     s_d;
    logic [7:0] a_q,     a_d;
    logic [7:0] chk_q,   chk_d;
    logic [7:0] last_sent_q, last_sent_d;
    logic       pending_q,   pending_d;
    logic [7:0] tcnt_q,      tcnt_d;

    logic       w_per;
    logic       w_chg;
    logic       w_trig;
    logic       w_start;
    logic [2:0] w_sel;
    logic [7:0] w_byte;
    logic       w_ser_busy;
    logic       w_ser_done;
    logic       w_frame_done;

    assign w_per  = tick && (tcnt_q == TICK_LAST);
    assign tcnt_d = w_per ? 8'd0 : (tick ? tcnt_q + 8'd1 : tcnt_q);

    // While a frame is in flight, changes are judged against the S being sent.
    always_comb begin
        w_chg = 1'b0;
        case (state_q)
            ST_IDLE: w_chg = (status != last_sent_q);
            ST_LOAD: w_chg = 1'b0;
            default: w_chg = (status != s_q);
        endcase
    end
    assign w_trig = w_per || w_chg;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        s_d          = s_q;
        a_d          = a_q;
        chk_d        = chk_q;
        last_sent_d  = last_sent_q;
        pending_d    = pending_q;
        w_start      = 1'b0;
        w_sel        = idx_q;
        w_frame_done = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_trig || pending_q) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                s_d       = status;
                a_d       = aux;
                chk_d     = frame_chk(FTYPE, status, aux);
                pending_d = w_per;
                idx_d     = 3'd0;
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                if (w_trig) begin
                    pending_d = 1'b1;
                end
                if (!w_ser_busy) begin
                    w_start = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_trig) begin
                    pending_d = 1'b1;
                end
                if (w_ser_done) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        // Hand the next byte over in the done cycle: no gap between bytes.
                        idx_d   = idx_q + 3'd1;
                        w_sel   = idx_q + 3'd1;
                        w_start = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                w_frame_done = 1'b1;
                last_sent_d  = s_q;
                state_d      = (w_trig || pending_q) ? ST_LOAD : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        case (w_sel)
            3'd0:    w_byte = SOF;
            3'd1:    w_byte = FTYPE;
            3'd2:    w_byte = s_q;
            3'd3:    w_byte = a_q;
            default: w_byte = chk_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= 3'd0;
            s_q         <= 8'h00;
            a_q         <= 8'h00;
            chk_q       <= 8'h00;
            last_sent_q <= 8'h00;
            pending_q   <= 1'b0;
            tcnt_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            s_q         <= s_d;
            a_q         <= a_d;
            chk_q       <= chk_d;
            last_sent_q <= last_sent_d;
            pending_q   <= pending_d;
            tcnt_q      <= tcnt_d;
        end
    end

    uart_byte_tx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_ser (
        .clk   (clk),
        .rst   (rst),
        .start (w_start),
        .data  (w_byte),
        .tx    (tx),
        .busy  (w_ser_busy),
        .done  (w_ser_done)
    );

    assign busy       = (state_q != ST_IDLE);
    assign frame_done = w_frame_done;

endmodule
`default_nettype wire
